vga_fb_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between the VGA scan-out reader and a pixel writer.

---
 rtl/vga_fb_pkg.sv | 15 +
 rtl/vga_fb_rd_pipe.sv | 41 ++++
 rtl/vga_fb_arbiter.sv | 129 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
// Holds the FSM state encoding, the default bus widths and the read latency.
package vga_fb_pkg;

    localparam int FB_AW  = 17;
    localparam int FB_DW  = 12;
    localparam int RD_LAT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } fb_state_t;

endpackage

// File: rtl/vga_fb_rd_pipe.sv
// Display read return path: valid shift register plus the RAM data capture stage.
// The pixel stays on disp_data until the next valid read replaces it.
module vga_fb_rd_pipe
    import vga_fb_pkg::*;
#(
    parameter int DW = FB_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rd_grant,
    input  logic [DW-1:0] mem_rdata,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DW-1:0]     data_q, data_d;

    // vld_q[0] marks the cycle the read is on the RAM pins, vld_q[1] the return cycle
    always_comb begin
        vld_d  = {vld_q[RD_LAT-2:0], rd_grant};
        data_d = data_q;
        if (vld_q[RD_LAT-2]) begin
            data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign disp_valid = vld_q[RD_LAT-1];
    assign disp_data  = data_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, writes fill idle slots.
// Define VGA_FB_VBLANK_WR_EN to restrict write grants to vertical blanking.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int AW      = FB_AW,
    parameter int DW      = FB_DW,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               disp_req,
    input  logic [AW-1:0]      disp_addr,
    output logic               disp_valid,
    output logic [DW-1:0]      disp_data,
    input  logic               vblank,
    input  logic               wr_req,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    output logic               wr_ack,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic [STALL_W-1:0] wr_stall
);

    fb_state_t          state_q, state_d;
    logic               wr_ok;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic               wr_ack_q, wr_ack_d;
    logic [STALL_W-1:0] stall_q, stall_d;

`ifdef VGA_FB_VBLANK_WR_EN
    assign wr_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign wr_ok         = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WR mask stops a re-grant while the writer is still dropping wr_req
    always_comb begin
        state_d = IDLE;
        if (disp_req) begin
            state_d = RD;
        end else if (wr_ok && wr_req && (state_q != WR)) begin
            state_d = WR;
        end
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        unique case (state_d)
            RD: begin
                mem_en_d   = 1'b1;
                mem_addr_d = disp_addr;
            end
            WR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
                wr_ack_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (wr_req && (state_d != WR) && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            stall_q     <= stall_d;
        end
    end

    vga_fb_rd_pipe #(
        .DW (DW)
    ) u_rd_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_grant   (state_d == RD),
        .mem_rdata  (mem_rdata),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_ack    = wr_ack_q;
    assign wr_stall  = stall_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
// Build with VGA_FB_VBLANK_WR_EN defined to exercise blank-only writes.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [16:0] disp_addr = '0;
    logic        disp_valid;
    logic [11:0] disp_data;
    logic        vblank = 1'b1;
    logic        wr_req = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic [15:0] wr_stall;

    logic [11:0] ram  [0:131071];
    bit          mark [0:131071];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .vblank     (vblank),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wr_stall   (wr_stall)
    );

    function automatic logic [11:0] pat(input logic [16:0] a);
        if (a == 17'h10) return 12'hF0F;
        return a[11:0] ^ 12'hA5A;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]  <= mem_wdata;
                mark[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= mark[mem_addr] ? ram[mem_addr] : pat(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        disp_req = 1'b0;
        wr_req   = 1'b0;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n  = 1'b1;
        tick();
    endtask

    initial begin
        int rq[$];
        int r;
        int nv;
        int na;
        int wi;
        logic prev_ack;

        do_reset();
        chk("rst_en", mem_en, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_data", disp_data, 0);
        chk("rst_stall", wr_stall, 0);

        // single display read
        disp_req = 1'b1;
        disp_addr = 17'h10;
        tick();
        disp_req = 1'b0;
        chk("t1_en", mem_en, 1);
        chk("t1_we", mem_we, 0);
        chk("t1_addr", mem_addr, 17'h10);
        tick();
        chk("t1_v_t2", disp_valid, 0);
        tick();
        chk("t1_v_t3", disp_valid, 1);
        chk("t1_data", disp_data, 12'hF0F);
        tick();
        chk("t1_v_t4", disp_valid, 0);
        chk("t1_hold", disp_data, 12'hF0F);

        // single write, wr_req held through the ack cycle
        wr_req = 1'b1;
        wr_addr = 17'h20;
        wr_data = 12'hABC;
        tick();
        chk("t2_ack", wr_ack, 1);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 17'h20);
        chk("t2_wdata", mem_wdata, 12'hABC);
        tick();
        chk("t2_no_2nd_ack", wr_ack, 0);
        chk("t2_we_off", mem_we, 0);
        wr_req = 1'b0;
        tick();
        chk("t2_ram", ram[17'h20], 12'hABC);
        chk("t2_noack", wr_ack, 0);

        // collision
        do_reset();
        disp_req = 1'b1;
        disp_addr = 17'h30;
        wr_req = 1'b1;
        wr_addr = 17'h40;
        wr_data = 12'h123;
        tick();
        disp_req = 1'b0;
        chk("t3_rd_first", mem_we, 0);
        chk("t3_rd_addr", mem_addr, 17'h30);
        chk("t3_ack_wait", wr_ack, 0);
        chk("t3_stall", wr_stall, 1);
        tick();
        chk("t3_ack", wr_ack, 1);
        chk("t3_wr_addr", mem_addr, 17'h40);
        wr_req = 1'b0;
        tick();
        chk("t3_stall_end", wr_stall, 1);
        chk("t3_valid", disp_valid, 1);
        chk("t3_rdata", disp_data, 12'h030 ^ 12'hA5A);
        chk("t3_ram", ram[17'h40], 12'h123);

        // 640 reads every 2nd clk with a continuous writer
        do_reset();
        nv = 0;
        na = 0;
        wi = 0;
        prev_ack = 1'b0;
        for (int c = 0; c < 1290; c++) begin
            disp_req = (c < 1280) && (c % 2 == 0);
            disp_addr = 17'(32'h1000 + c / 2);
            if (disp_req) rq.push_back(c);
            wr_req = (wi < 640);
            wr_addr = 17'(32'h200 + wi);
            wr_data = 12'(32'h800 + wi);
            tick();
            if (disp_valid) begin
                nv++;
                if (rq.size() == 0) begin
                    chk("t4_spurious", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("t4_lat", 32'(c + 1 - r), 3);
                    chk("t4_data", disp_data, pat(17'(32'h1000 + r / 2)));
                end
            end
            if (wr_ack) begin
                na++;
                chk("t4_ack_gap", prev_ack, 0);
                chk("t4_waddr", mem_addr, 32'h200 + wi);
                wi++;
            end
            prev_ack = wr_ack;
        end
        chk("t4_nvalid", nv, 640);
        chk("t4_nack", na, 640);
        chk("t4_ram_first", ram[17'h200], 12'h800);
        chk("t4_ram_last", ram[17'h47F], 12'hA7F);

        // vblank gating of writes
        do_reset();
`ifdef VGA_FB_VBLANK_WR_EN
        vblank = 1'b0;
        wr_req = 1'b1;
        wr_addr = 17'h50;
        wr_data = 12'h555;
        na = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wr_ack) na++;
        end
        chk("t5_noack", na, 0);
        chk("t5_stall", wr_stall, 100);
        vblank = 1'b1;
        tick();
        chk("t5_ack", wr_ack, 1);
        wr_req = 1'b0;
        tick();
        chk("t5_ram", ram[17'h50], 12'h555);
`else
        vblank = 1'b0;
        wr_req = 1'b1;
        wr_addr = 17'h50;
        wr_data = 12'h555;
        tick();
        chk("t5_ack", wr_ack, 1);
        wr_req = 1'b0;
        tick();
        chk("t5_ram", ram[17'h50], 12'h555);
        chk("t5_stall", wr_stall, 0);
        vblank = 1'b1;
`endif

        // reset in the middle of a read with a write pending
        do_reset();
        disp_req = 1'b1;
        disp_addr = 17'h60;
        wr_req = 1'b1;
        wr_addr = 17'h70;
        wr_data = 12'h777;
        tick();
        disp_req = 1'b0;
        chk("t6_pre_en", mem_en, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_en", mem_en, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_ack", wr_ack, 0);
        chk("t6_valid", disp_valid, 0);
        chk("t6_data", disp_data, 0);
        chk("t6_stall", wr_stall, 0);
        tick();
        wr_req = 1'b0;
        reset_n = 1'b1;
        nv = 0;
        na = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (disp_valid) nv++;
            if (wr_ack) na++;
        end
        chk("t6_no_valid", nv, 0);
        chk("t6_no_ack", na, 0);

        // starvation under back-to-back reads and stall saturation
        na = 0;
        disp_req = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 65545; i++) begin
            disp_addr = 17'(i);
            tick();
            if (wr_ack) na++;
            if (i == 999) chk("t6_stall_1000", wr_stall, 1000);
            if (i == 65539) chk("t6_stall_sat", wr_stall, 16'hFFFF);
        end
        chk("t6_stall_nowrap", wr_stall, 16'hFFFF);
        chk("t6_starve", na, 0);
        disp_req = 1'b0;
        wr_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
